zigzag_block_sequencer: RTL and testbench
=========================================

Name: zigzag_block_sequencer

Overview:
- Sequences the 64x8-bit zigzag data buffer, one 8x8 block at a time.
- Accepts blocks from the upstream pixel/quantiser stage through a valid/ready handshake and strobes the buffer load.
- Runs the zigzag reorder enable for its pipeline latency, then holds the 512-bit reordered word valid until the entropy coder takes it.
- Counts blocks per frame and flags the frame end.

Parameters:
- ZZ_LATENCY, 1: cycles zz_en is held after a load before the reordered output is stable (range 1..15).
- CNT_W, 16: width of block counter, frame-size and stall-counter fields.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- blk_valid  in  1  upstream presents a full 8x8 block on the buffer's pixel bus.
- blk_ready  out  1  sequencer can accept a block this cycle.
- load_en  out  1  drives the buffer's input_data_enable; buffer captures on this edge.
- zz_en  out  1  drives the zigzag reorder enable.
- out_valid  out  1  reordered 512-bit word is valid.
- out_ready  in  1  downstream accepts the word.
- frame_blocks  in  CNT_W  blocks per frame; 0 = no frame boundary.
- blk_count  out  CNT_W  blocks delivered in the current frame.
- frame_done  out  1  one-cycle pulse after the last block of a frame is delivered.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE, blk_count = 0.
  - frame_done, out_valid and zz_en = 0; the latency counter is cleared.
  - blk_ready, load_en and busy follow the combinational equations below. In IDLE this gives blk_ready = 1, load_en = blk_valid and busy = 0.
  - Reset mid-operation drops any block in flight; no output handshake occurs.
- States: IDLE, ZZ, HOLD.
- Combinational outputs:
  - blk_ready = (state==IDLE) | (state==HOLD & out_ready).
  - load_en = blk_valid & blk_ready (Mealy); the accept edge is the load edge.
- IDLE:
  - On accept -> ZZ, latency counter = ZZ_LATENCY-1.
- ZZ:
  - zz_en = 1.
  - Counter decrements each cycle; at 0 -> HOLD.
  - Load at edge T gives zz_en high for cycles T+1..T+ZZ_LATENCY and out_valid first high in cycle T+ZZ_LATENCY+1.
  - blk_valid is ignored (blk_ready = 0).
- HOLD:
  - out_valid = 1 and zz_en = 0; the reorder output stays frozen.
  - On out_ready with blk_valid: simultaneous delivery and accept -> ZZ (back-to-back, no bubble in IDLE).
  - On out_ready without blk_valid -> IDLE.
  - On !out_ready: stay; no load and no re-enable, so the output must not change.
- Delivery event: out_valid & out_ready.
  - frame_blocks != 0: if blk_count == frame_blocks-1, then blk_count <= 0 and frame_done <= 1 for the next cycle; else blk_count++.
  - frame_blocks == 0: blk_count increments and wraps modulo 2^CNT_W; frame_done never asserts.
- frame_blocks is sampled only at delivery events. Changing it mid-frame takes effect at the next delivery.
- A frame of 1 block pulses frame_done on every delivery.
- out_valid and zz_en are never high in the same cycle.

Optional Feature:
- ZZ_STALL_CNT_EN defined:
  - Adds output port stall_cycles [CNT_W-1:0], reset 0.
  - Increments on each cycle with out_valid & !out_ready, saturating at all-ones.
  - Cleared to 0 in the cycle after frame_done (the frame_done cycle still shows the final value).
- Undefined: port and counter absent; the rest of the behaviour is identical.

Decomposition:
- Package zigzag_ctrl_pkg holds:
  - typedef enum for states {IDLE, ZZ, HOLD};
  - localparam default ZZ_LATENCY;
  - BLK_PIXELS=64;
  - the bus width constant 512.
- One sub-module, zz_frame_counter: block counter, frame_done generation and optional stall counter. It takes the delivery strobe, out_valid, out_ready and frame_blocks.
- The FSM stays in the top module.

Test Plan:
- Single block, ZZ_LATENCY=1, out_ready=1:
  - blk_valid at cycle 0 -> load_en=1 at cycle 0, zz_en=1 at cycle 1, out_valid=1 at cycle 2 and dropped at cycle 3.
  - blk_count goes 0->1.
- Backpressure, out_ready=0 for 5 cycles in HOLD:
  - out_valid stays 1, zz_en=0, blk_ready=0 and load_en=0 throughout despite blk_valid=1.
  - With ZZ_STALL_CNT_EN, stall_cycles=5.
- Back-to-back, blk_valid=1 and out_ready=1 continuously, ZZ_LATENCY=2:
  - One accept every 3 cycles; load_en coincides with each delivery.
  - Never returns to IDLE.
- frame_blocks=3, 4 deliveries:
  - blk_count 1,2,0,1; frame_done pulses exactly once, in the cycle after the 3rd delivery.
  - frame_blocks=0 with 2^CNT_W+1 deliveries (CNT_W=4): count wraps to 1, no frame_done.
- reset_n low in ZZ and again in HOLD:
  - Immediately out_valid=0, zz_en=0, blk_count=0, state IDLE.
  - After release blk_ready=1, and a new block completes normally.

Source files
------------

// File: rtl/zigzag_ctrl_pkg.sv
// Shared types and constants for the zigzag block sequencer.
package zigzag_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZZ   = 2'd1,
        HOLD = 2'd2
    } zz_state_t;

    localparam int ZZ_LATENCY_DEFAULT = 1;
    localparam int BLK_PIXELS         = 64;
    localparam int PIX_W              = 8;
    localparam int ZZ_BUS_W           = 512;

    // Widest latency counter needed for the supported 1..15 latency range.
    localparam int LAT_W = 4;

endpackage

// File: rtl/zz_frame_counter.sv
// Per-frame block counter with frame_done pulse; optional stall counter under ZZ_STALL_CNT_EN.
module zz_frame_counter
    import zigzag_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             deliver,
    input  logic             out_valid,
    input  logic             out_ready,
    input  logic [CNT_W-1:0] frame_blocks,
    output logic [CNT_W-1:0] blk_count,
    output logic             frame_done
`ifdef ZZ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    logic last_blk;

    // frame_blocks == 0 means no frame boundary: count simply wraps.
    assign last_blk = (frame_blocks != '0) && (blk_count == frame_blocks - CNT_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blk_count  <= '0;
            frame_done <= 1'b0;
        end else if (deliver) begin
            blk_count  <= last_blk ? '0 : blk_count + CNT_W'(1);
            frame_done <= last_blk;
        end else begin
            frame_done <= 1'b0;
        end
    end

`ifdef ZZ_STALL_CNT_EN
    // frame_done cycle still shows the final count; cleared on the following edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (frame_done) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
`else
    logic unused_stall_inputs;
    assign unused_stall_inputs = out_valid ^ out_ready;
`endif

endmodule

// File: rtl/zigzag_block_sequencer.sv
// Load / reorder / hold sequencer for the 64x8-bit zigzag buffer.
// Optional stall counter port enabled by defining ZZ_STALL_CNT_EN.
module zigzag_block_sequencer
    import zigzag_ctrl_pkg::*;
#(
    parameter int ZZ_LATENCY = ZZ_LATENCY_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic             load_en,
    output logic             zz_en,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [CNT_W-1:0] frame_blocks,
    output logic [CNT_W-1:0] blk_count,
    output logic             frame_done,
    output logic             busy
`ifdef ZZ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ZZ_LATENCY - 1);

    zz_state_t        state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             deliver;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        blk_ready = 1'b0;
        zz_en     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                blk_ready = 1'b1;
                busy      = 1'b0;
                if (blk_valid) begin
                    state_d = ZZ;
                    lat_d   = LAT_LOAD;
                end
            end
            ZZ: begin
                zz_en = 1'b1;
                if (lat_q == '0) begin
                    state_d = HOLD;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                blk_ready = out_ready;
                // Delivery and the next accept share one edge, so no IDLE bubble.
                if (out_ready) begin
                    if (blk_valid) begin
                        state_d = ZZ;
                        lat_d   = LAT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                lat_d   = '0;
            end
        endcase
    end

    assign load_en = blk_valid & blk_ready;
    assign deliver = out_valid & out_ready;

    zz_frame_counter #(
        .CNT_W(CNT_W)
    ) u_frame_counter (
        .clock       (clock),
        .reset_n     (reset_n),
        .deliver     (deliver),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_blocks(frame_blocks),
        .blk_count   (blk_count),
        .frame_done  (frame_done)
`ifdef ZZ_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

endmodule

// File: tb/tb_zigzag_block_sequencer.sv
// Bench for zigzag_block_sequencer: transaction-level model plus directed literal checks.
module tb_zigzag_block_sequencer;

    localparam int L     = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             blk_valid;
    logic             blk_ready;
    logic             load_en;
    logic             zz_en;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] frame_blocks;
    logic [CNT_W-1:0] blk_count;
    logic             frame_done;
    logic             busy;
`ifdef ZZ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    zigzag_block_sequencer #(
        .ZZ_LATENCY(L),
        .CNT_W     (CNT_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .load_en     (load_en),
        .zz_en       (zz_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_blocks(frame_blocks),
        .blk_count   (blk_count),
        .frame_done  (frame_done),
        .busy        (busy)
`ifdef ZZ_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a block in flight is described by k = cycles since its load edge.
    bit m_busy  = 0;
    int m_k     = 0;
    int m_cnt   = 0;
    bit m_fd    = 0;
    int m_stall = 0;

    always @(negedge clock) begin
        bit e_zz, e_ov, e_rdy, e_ld, deliver, fd_old;
        if (!reset_n) begin
            m_busy = 0; m_k = 0; m_cnt = 0; m_fd = 0; m_stall = 0;
        end
        e_zz  = m_busy && (m_k <= L);
        e_ov  = m_busy && (m_k > L);
        e_rdy = !m_busy || (e_ov && out_ready);
        e_ld  = blk_valid && e_rdy;
        check("m_zz_en",      int'(zz_en),      int'(e_zz));
        check("m_out_valid",  int'(out_valid),  int'(e_ov));
        check("m_blk_ready",  int'(blk_ready),  int'(e_rdy));
        check("m_load_en",    int'(load_en),    int'(e_ld));
        check("m_busy",       int'(busy),       int'(m_busy));
        check("m_blk_count",  int'(blk_count),  m_cnt);
        check("m_frame_done", int'(frame_done), int'(m_fd));
        check("m_exclusive",  int'(zz_en & out_valid), 0);
`ifdef ZZ_STALL_CNT_EN
        check("m_stall", int'(stall_cycles), m_stall);
`endif
        if (reset_n) begin
            deliver = e_ov && out_ready;
            fd_old  = m_fd;
            if (deliver) begin
                if (frame_blocks != 0 && m_cnt == int'(frame_blocks) - 1) begin
                    m_cnt = 0; m_fd = 1;
                end else begin
                    m_cnt = (m_cnt + 1) % (CMAX + 1); m_fd = 0;
                end
            end else begin
                m_fd = 0;
            end
            if (fd_old) m_stall = 0;
            else if (e_ov && !out_ready && m_stall < CMAX) m_stall++;
            if (e_ld) begin
                m_busy = 1; m_k = 1;
            end else if (deliver) begin
                m_busy = 0;
            end else if (m_busy && m_k <= L) begin
                m_k++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    int fd_seen;

    task automatic run_block();
        blk_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clock); fd_seen += int'(frame_done);
        tick();
        blk_valid = 1'b0;
        repeat (3) begin
            @(negedge clock); fd_seen += int'(frame_done);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int loads, idle_seen;
        int exp_cnt[4];
        int exp_fd[4];
        exp_cnt = '{1, 2, 0, 1};
        exp_fd  = '{0, 0, 1, 0};

        reset_n = 1'b0; blk_valid = 1'b0; out_ready = 1'b0; frame_blocks = '0;
        tick();
        @(negedge clock);
        check("rst_blk_ready", int'(blk_ready), 1);
        check("rst_busy",      int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_blk_count", int'(blk_count), 0);
        tick();
        reset_n = 1'b1;

        // Single block: load at 0, zz_en 1..2, out_valid at 3 only.
        blk_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock); check("t1_load_c0", int'(load_en), 1);
        tick(); blk_valid = 1'b0;
        @(negedge clock); check("t1_zz_c1", int'(zz_en), 1);
        tick();
        @(negedge clock); check("t1_zz_c2", int'(zz_en), 1);
        tick();
        @(negedge clock); check("t1_ov_c3", int'(out_valid), 1);
        tick();
        @(negedge clock);
        check("t1_ov_c4", int'(out_valid), 0);
        check("t1_cnt_c4", int'(blk_count), 1);
        tick();

        // Backpressure: five HOLD cycles with out_ready low while blk_valid stays high.
        blk_valid = 1'b1; out_ready = 1'b0;
        repeat (3) tick();
        repeat (5) begin
            @(negedge clock);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_zz_en",     int'(zz_en), 0);
            check("bp_blk_ready", int'(blk_ready), 0);
            check("bp_load_en",   int'(load_en), 0);
            tick();
        end
`ifdef ZZ_STALL_CNT_EN
        @(negedge clock); check("bp_stall", int'(stall_cycles), 5);
`endif
        out_ready = 1'b1;
        @(negedge clock); check("bp_release_load", int'(load_en), 1);
        tick(); blk_valid = 1'b0;
        repeat (5) tick();

        // Back-to-back: one accept every L+1 cycles, never idle.
        blk_valid = 1'b1; out_ready = 1'b1;
        loads = 0; idle_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            loads += int'(load_en);
            if (c > 0 && !busy) idle_seen++;
            tick();
        end
        check("b2b_loads", loads, 4);
        check("b2b_idle",  idle_seen, 0);
        blk_valid = 1'b0;
        repeat (4) tick();

        // Reset while in ZZ.
        blk_valid = 1'b1; tick(); blk_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        check("rz_out_valid", int'(out_valid), 0);
        check("rz_zz_en",     int'(zz_en), 0);
        check("rz_blk_count", int'(blk_count), 0);
        check("rz_busy",      int'(busy), 0);
        tick(); reset_n = 1'b1;

        // Reset while in HOLD.
        blk_valid = 1'b1; out_ready = 1'b0; tick(); blk_valid = 1'b0;
        repeat (3) tick();
        @(negedge clock); check("rh_pre_ov", int'(out_valid), 1);
        tick();
        reset_n = 1'b0;
        @(negedge clock);
        check("rh_out_valid", int'(out_valid), 0);
        check("rh_zz_en",     int'(zz_en), 0);
        check("rh_busy",      int'(busy), 0);
        tick(); reset_n = 1'b1;
        @(negedge clock); check("rh_blk_ready", int'(blk_ready), 1);
        tick();
        fd_seen = 0;
        run_block();
        @(negedge clock); check("rh_after_cnt", int'(blk_count), 1);
        tick();

        // Frame of 3 blocks, 4 deliveries.
        do_reset();
        frame_blocks = 4'd3;
        fd_seen = 0;
        for (int b = 0; b < 4; b++) begin
            run_block();
            @(negedge clock);
            check("fr_cnt", int'(blk_count), exp_cnt[b]);
            check("fr_done", int'(frame_done), exp_fd[b]);
            fd_seen += int'(frame_done);
            tick();
        end
        check("fr_pulses", fd_seen, 1);

        // No frame boundary: 17 deliveries wrap a 4-bit count to 1.
        do_reset();
        frame_blocks = '0;
        fd_seen = 0;
        for (int b = 0; b < 17; b++) begin
            run_block();
            @(negedge clock); fd_seen += int'(frame_done);
            tick();
        end
        @(negedge clock);
        check("wrap_cnt", int'(blk_count), 1);
        check("wrap_pulses", fd_seen, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
